// File: rtl/hazard_forward.sv
// Forwarding-select and load-use stall unit for a 5-stage pipeline (ID -> EX -> MEM).
// Optional feature: define HAZARD_STATS_EN to add the saturating stall_count output.
module hazard_forward (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_dst,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_use_imm,
  input  logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall
`ifdef HAZARD_STATS_EN
  ,output logic [15:0] stall_count
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // Register 0 is hardwired, so it is never a forwarding source.
  function automatic logic produces(input logic vld, input logic wr,
                                    input logic [4:0] dst, input logic [4:0] r);
    return vld && wr && (r != 5'd0) && (dst == r);
  endfunction

  function automatic logic [1:0] pick_src(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return SEL_EX;
    else if (mem_hit) return SEL_MEM;
    else              return SEL_RF;
  endfunction

  // EX slot (_p1) and MEM slot (_p2). The MEM slot never feeds the stall check,
  // so its load flag is not kept.
  logic       ex_vld_p1;
  logic [4:0] ex_dst_p1;
  logic       ex_wr_p1;
  logic       ex_ld_p1;
  logic       mem_vld_p2;
  logic [4:0] mem_dst_p2;
  logic       mem_wr_p2;

  logic       load_hit_p0;
  logic       vld_p0;
  logic [1:0] a_sel_p0;
  logic [1:0] b_sel_p0;

  // ---- p0: ID-stage hazard detection and selector computation ----
  always_comb begin
    load_hit_p0 = ex_vld_p1 && ex_ld_p1 && (ex_dst_p1 != 5'd0) &&
                  ((ex_dst_p1 == id_rs) || (!id_use_imm && (ex_dst_p1 == id_rt)));
    stall       = id_valid && !flush && load_hit_p0;
    vld_p0      = id_valid && !flush && !load_hit_p0;
    a_sel_p0    = SEL_RF;
    b_sel_p0    = SEL_RF;
    if (vld_p0) begin
      a_sel_p0 = pick_src(produces(ex_vld_p1, ex_wr_p1, ex_dst_p1, id_rs),
                          produces(mem_vld_p2, mem_wr_p2, mem_dst_p2, id_rs));
      if (id_use_imm)
        b_sel_p0 = SEL_IMM;
      else
        b_sel_p0 = pick_src(produces(ex_vld_p1, ex_wr_p1, ex_dst_p1, id_rt),
                            produces(mem_vld_p2, mem_wr_p2, mem_dst_p2, id_rt));
    end
  end

  // ---- p1/p2: slot advance and registered selectors ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_p1  <= 1'b0;
      ex_dst_p1  <= 5'd0;
      ex_wr_p1   <= 1'b0;
      ex_ld_p1   <= 1'b0;
      mem_vld_p2 <= 1'b0;
      mem_dst_p2 <= 5'd0;
      mem_wr_p2  <= 1'b0;
      fwd_a_sel  <= SEL_RF;
      fwd_b_sel  <= SEL_RF;
    end else begin
      mem_vld_p2 <= ex_vld_p1;
      mem_dst_p2 <= ex_dst_p1;
      mem_wr_p2  <= ex_wr_p1;
      ex_vld_p1  <= vld_p0;
      ex_dst_p1  <= vld_p0 ? id_dst : 5'd0;
      ex_wr_p1   <= vld_p0 && id_reg_write;
      ex_ld_p1   <= vld_p0 && id_mem_read;
      fwd_a_sel  <= a_sel_p0;
      fwd_b_sel  <= b_sel_p0;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= 16'd0;
    else if (stall)
      stall_count <= sat_inc(stall_count);
  end
`endif

endmodule

// File: tb/tb_hazard_forward.sv
// Scoreboard bench for hazard_forward: a queue-based pipeline model predicts stall and selectors.
module tb_hazard_forward;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_use_imm;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  hazard_forward dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_use_imm(id_use_imm), .flush(flush), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit [4:0] dst;
    bit       wr;
    bit       ld;
  } instr_t;

  instr_t hist[$];          // instructions in program order as they entered EX; last = EX, prev = MEM
  bit     exp_stall_q[$];
  bit [1:0] exp_a_q[$];
  bit [1:0] exp_b_q[$];
  int     exp_cnt_q[$];
  int     exp_cnt;
  bit     rst_active;
  int     checks;
  int     errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_producer(input instr_t e, input bit [4:0] r);
    return e.v && e.wr && r != 0 && e.dst == r;
  endfunction

  function automatic bit [1:0] source_of(input bit [4:0] r);
    if (is_producer(hist[hist.size()-1], r)) return 2'b01;
    if (is_producer(hist[hist.size()-2], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    instr_t b;
    b = '0;
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    exp_stall_q.delete();
    exp_a_q.delete();
    exp_b_q.delete();
    exp_cnt_q.delete();
    exp_cnt = 0;
  endtask

  task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] dst,
                      input bit wr, input bit ld, input bit imm, input bit fl, output bit st);
    instr_t ex, nxt;
    bit acc;
    bit [1:0] a, b;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_reg_write = wr; id_mem_read = ld; id_use_imm = imm; flush = fl;
    #1;
    ex  = hist[hist.size()-1];
    st  = v && !fl && ex.v && ex.ld && ex.dst != 0 && (ex.dst == rs || (!imm && ex.dst == rt));
    acc = v && !fl && !st;
    a = 2'b00;
    b = 2'b00;
    if (acc) begin
      a = source_of(rs);
      b = imm ? 2'b11 : source_of(rt);
    end
    if (st && exp_cnt < 65535) exp_cnt++;
    exp_stall_q.push_back(st);
    exp_a_q.push_back(a);
    exp_b_q.push_back(b);
    exp_cnt_q.push_back(exp_cnt);
    nxt = '0;
    if (acc) begin
      nxt.v = 1'b1; nxt.dst = dst; nxt.wr = wr; nxt.ld = ld;
    end
    hist.push_back(nxt);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  // Stall monitor: combinational output, sampled after the driver has settled inputs.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_active && exp_stall_q.size() > 0)
      chk("stall", stall, exp_stall_q.pop_front());
  end

  // Selector monitor: registered outputs, sampled just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_active && exp_a_q.size() > 0) begin
      chk("fwd_a_sel", fwd_a_sel, exp_a_q.pop_front());
      chk("fwd_b_sel", fwd_b_sel, exp_b_q.pop_front());
`ifdef HAZARD_STATS_EN
      chk("stall_count", stall_count, exp_cnt_q.pop_front());
`else
      void'(exp_cnt_q.pop_front());
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    bit st;
    bit held;
    bit v, wr, ld, imm, fl;
    bit [4:0] rs, rt, dst;
    checks = 0; errors = 0;
    rst_active = 1'b1;
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
    id_reg_write = 0; id_mem_read = 0; id_use_imm = 0; flush = 0;
    model_reset();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_a", fwd_a_sel, 0);
    chk("rst_b", fwd_b_sel, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_active = 1'b0;

    // add r3 ; add rs=3 rt=4
    step(1, 0, 0, 3, 1, 0, 0, 0, st);
    step(1, 3, 4, 8, 1, 0, 0, 0, st);
    // add r5 ; unrelated ; rs=5 rt=5
    step(1, 1, 2, 5, 1, 0, 0, 0, st);
    step(1, 1, 2, 9, 1, 0, 0, 0, st);
    step(1, 5, 5, 10, 1, 0, 0, 0, st);
    // lw r7 ; add rs=7 (stalls once, then re-issued)
    step(1, 1, 0, 7, 1, 1, 0, 0, st);
    step(1, 7, 4, 11, 1, 0, 0, 0, st);
    step(1, 7, 4, 11, 1, 0, 0, 0, st);
    // add r0 ; add rs=0 ; lw r2 ; addi rs=9 rt=2 imm
    step(1, 1, 1, 0, 1, 0, 0, 0, st);
    step(1, 0, 0, 12, 1, 0, 0, 0, st);
    step(1, 1, 0, 2, 1, 1, 0, 0, st);
    step(1, 9, 2, 13, 1, 0, 1, 0, st);
    // lw r7 ; add rs=7 flushed in the would-be stall cycle
    step(1, 1, 0, 7, 1, 1, 0, 0, st);
    step(1, 7, 4, 14, 1, 0, 0, 1, st);
    step(0, 7, 4, 14, 1, 0, 0, 0, st);

    // Randomized traffic; a stalled instruction is held in ID until accepted.
    held = 0;
    v = 0; rs = 0; rt = 0; dst = 0; wr = 0; ld = 0; imm = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        v   = ($urandom_range(0, 9) != 0);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        dst = 5'($urandom_range(0, 7));
        ld  = ($urandom_range(0, 2) == 0);
        wr  = ld || ($urandom_range(0, 3) != 0);
        imm = ($urandom_range(0, 3) == 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      step(v, rs, rt, dst, wr, ld, imm, fl, st);
      held = st;
    end

    // Reset asserted in the middle of a load-use stall.
    step(1, 1, 0, 7, 1, 1, 0, 0, st);
    @(negedge clk);
    id_valid = 1; id_rs = 7; id_rt = 4; id_dst = 15;
    id_reg_write = 1; id_mem_read = 0; id_use_imm = 0; flush = 0;
    #1;
    chk("pre_rst_stall", stall, 1);
    rst_active = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_a", fwd_a_sel, 0);
    chk("mid_rst_b", fwd_b_sel, 0);
`ifdef HAZARD_STATS_EN
    chk("mid_rst_count", stall_count, 0);
`endif
    model_reset();
    id_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_active = 1'b0;
    step(1, 7, 4, 15, 1, 0, 0, 0, st);
    step(1, 15, 7, 16, 1, 0, 0, 0, st);
    step(0, 0, 0, 0, 0, 0, 0, 0, st);

    repeat (3) @(negedge clk);
    chk("sel_queue_drained", exp_a_q.size(), 0);
    chk("stall_queue_drained", exp_stall_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
